multicycle_control: RTL and testbench

Multi-cycle control unit: a synchronous FSM that drives the shared-ALU, shared-memory datapath. It replaces single-cycle opcode decode with a per-instruction state sequence and keeps the same 4-bit ISA encoding. It adds a memory-ready handshake, branch-condition encoding, a retire strobe, and illegal-opcode and memory-timeout detection.

---
 rtl/multicycle_pkg.sv | 87 ++++++++
 rtl/mc_output_decode.sv | 128 ++++++++++++
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding, the
// 4-bit ISA opcode map, datapath select codes and opcode helper functions.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10
    } state_e;

    // Opcodes
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ANDI = 4'b0010;
    localparam logic [3:0] OP_ORI  = 4'b0011;
    localparam logic [3:0] OP_SUBI = 4'b0100;
    localparam logic [3:0] OP_LHW  = 4'b0111;
    localparam logic [3:0] OP_SHW  = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BLT  = 4'b1011;
    localparam logic [3:0] OP_BGT  = 4'b1100;
    localparam logic [3:0] OP_JUMP = 4'b1111;

    // ALU operations
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    // ALU input B select
    localparam logic [1:0] ALU_B_REG = 2'b00;
    localparam logic [1:0] ALU_B_INC = 2'b01;
    localparam logic [1:0] ALU_B_IMM = 2'b10;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Branch condition select
    localparam logic [1:0] BR_EQ = 2'b00;
    localparam logic [1:0] BR_NE = 2'b01;
    localparam logic [1:0] BR_LT = 2'b10;
    localparam logic [1:0] BR_GT = 2'b11;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_SUBI,
            OP_LHW, OP_SHW,
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT,
            OP_JUMP: op_is_legal = 1'b1;
            default: op_is_legal = 1'b0;
        endcase
    endfunction

    // Successor of DECODE; illegal opcodes fall back to FETCH.
    function automatic state_e decode_next(input logic [3:0] op);
        case (op)
            OP_R:                              decode_next = EXEC_R;
            OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: decode_next = EXEC_I;
            OP_LHW, OP_SHW:                    decode_next = MEM_ADDR;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGT:    decode_next = BRANCH;
            OP_JUMP:                           decode_next = JUMP;
            default:                           decode_next = FETCH;
        endcase
    endfunction

    function automatic logic [1:0] branch_cond_of(input logic [3:0] op);
        case (op)
            OP_BNE:  branch_cond_of = BR_NE;
            OP_BLT:  branch_cond_of = BR_LT;
            OP_BGT:  branch_cond_of = BR_GT;
            default: branch_cond_of = BR_EQ;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control decode for the multi-cycle datapath.
// Ports:
//   i_state      current FSM state encoding
//   i_op         opcode in view (live opcode in DECODE, latched op otherwise)
//   i_mem_ready  memory handshake, qualifies FETCH loads and store retire
//   o_*          datapath control strobes and selects, retire, illegal_op
module mc_output_decode
    import multicycle_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALU_OP_W = 3
) (
    input  logic [3:0]          i_state,
    input  logic [OPCODE_W-1:0] i_op,
    input  logic                i_mem_ready,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic [1:0]          o_branch_cond,
    output logic                o_ir_write,
    output logic                o_i_or_d,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_mem_to_reg,
    output logic                o_reg_dst,
    output logic                o_reg_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [1:0]          o_pc_source,
    output logic                o_retire,
    output logic                o_illegal_op
);

    state_e     w_state;
    logic [3:0] w_op;
    logic [2:0] w_alu_op;

    assign w_state  = state_e'(i_state);
    assign w_op     = 4'(i_op);
    assign o_alu_op = ALU_OP_W'(w_alu_op);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_branch_cond   = BR_EQ;
        o_ir_write      = 1'b0;
        o_i_or_d        = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = ALU_B_REG;
        w_alu_op        = ALU_ADD;
        o_pc_source     = PC_SRC_ALU;
        o_retire        = 1'b0;
        o_illegal_op    = 1'b0;

        case (w_state)
            FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = ALU_B_INC;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            DECODE: begin
                // Branch target precomputed into ALUOut.
                o_alu_src_b  = ALU_B_IMM;
                o_illegal_op = ~op_is_legal(w_op);
            end
            EXEC_R: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALU_B_REG;
                w_alu_op    = ALU_FUNCT;
            end
            EXEC_I: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALU_B_IMM;
                case (w_op)
                    OP_SUBI: w_alu_op = ALU_SUB;
                    OP_ANDI: w_alu_op = ALU_AND;
                    OP_ORI:  w_alu_op = ALU_OR;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            WB_ALU: begin
                o_reg_write = 1'b1;
                o_reg_dst   = (w_op == OP_R);
                o_retire    = 1'b1;
            end
            MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALU_B_IMM;
            end
            MEM_RD: begin
                o_mem_read = 1'b1;
                o_i_or_d   = 1'b1;
            end
            MEM_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = 1'b1;
                o_retire     = 1'b1;
            end
            MEM_WR: begin
                o_mem_write = 1'b1;
                o_i_or_d    = 1'b1;
                o_retire    = i_mem_ready;
            end
            BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_src_b     = ALU_B_REG;
                w_alu_op        = ALU_SUB;
                o_pc_write_cond = 1'b1;
                o_pc_source     = PC_SRC_ALUOUT;
                o_branch_cond   = branch_cond_of(w_op);
                o_retire        = 1'b1;
            end
            JUMP: begin
                o_pc_write  = 1'b1;
                o_pc_source = PC_SRC_JUMP;
                o_retire    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit for the shared-ALU, shared-memory datapath.
// Holds the state register, the latched opcode, the memory wait counter and
// the sticky timeout flag; control outputs come from mc_output_decode.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_opcode         instruction opcode, sampled in DECODE
//   i_mem_ready      memory access completes this cycle
//   o_*              datapath controls, retire / illegal_op pulses,
//                    o_mem_fault (sticky), o_state_dbg (current state)
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_mem_ready,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic [1:0]          o_branch_cond,
    output logic                o_ir_write,
    output logic                o_i_or_d,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_mem_to_reg,
    output logic                o_reg_dst,
    output logic                o_reg_write,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [1:0]          o_pc_source,
    output logic                o_retire,
    output logic                o_illegal_op,
    output logic                o_mem_fault,
    output logic [3:0]          o_state_dbg
);

    // The counter is cleared on timeout, so it never needs to hold MEM_TIMEOUT.
    localparam int unsigned   CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [OPCODE_W-1:0] r_op;
    logic [OPCODE_W-1:0] w_op_view;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]    w_wait_cnt_next;
    logic                r_mem_fault;
    logic                w_waiting;
    logic                w_timeout;

    logic                w_pc_write;
    logic                w_pc_write_cond;
    logic [1:0]          w_branch_cond;
    logic                w_ir_write;
    logic                w_i_or_d;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_mem_to_reg;
    logic                w_reg_dst;
    logic                w_reg_write;
    logic                w_alu_src_a;
    logic [1:0]          w_alu_src_b;
    logic [ALU_OP_W-1:0] w_alu_op;
    logic [1:0]          w_pc_source;
    logic                w_retire;
    logic                w_illegal_op;

    // op_q only loads at the end of DECODE, so DECODE itself looks at the input.
    assign w_op_view = (r_state == DECODE) ? i_opcode : r_op;

    assign w_waiting = (r_state inside {FETCH, MEM_RD, MEM_WR}) && !i_mem_ready;
    assign w_timeout = TIMEOUT_EN && w_waiting && (r_wait_cnt == CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:    if (i_mem_ready) w_state_next = DECODE;
            DECODE:   w_state_next = decode_next(4'(i_opcode));
            EXEC_R:   w_state_next = WB_ALU;
            EXEC_I:   w_state_next = WB_ALU;
            WB_ALU:   w_state_next = FETCH;
            MEM_ADDR: w_state_next = (4'(r_op) == OP_SHW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (i_mem_ready) w_state_next = MEM_WB;
            MEM_WB:   w_state_next = FETCH;
            MEM_WR:   if (i_mem_ready) w_state_next = FETCH;
            BRANCH:   w_state_next = FETCH;
            JUMP:     w_state_next = FETCH;
            default:  w_state_next = FETCH;
        endcase
        if (w_timeout) begin
            w_state_next = FETCH;
        end
    end

    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (w_timeout || (w_state_next != r_state)) begin
            w_wait_cnt_next = '0;
        end else if (TIMEOUT_EN && w_waiting) begin
            w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= FETCH;
            r_op        <= '0;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_state == DECODE) begin
                r_op <= i_opcode;
            end
            if (w_timeout) begin
                r_mem_fault <= 1'b1;
            end
        end
    end

    mc_output_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .i_state         (r_state),
        .i_op            (w_op_view),
        .i_mem_ready     (i_mem_ready),
        .o_pc_write      (w_pc_write),
        .o_pc_write_cond (w_pc_write_cond),
        .o_branch_cond   (w_branch_cond),
        .o_ir_write      (w_ir_write),
        .o_i_or_d        (w_i_or_d),
        .o_mem_read      (w_mem_read),
        .o_mem_write     (w_mem_write),
        .o_mem_to_reg    (w_mem_to_reg),
        .o_reg_dst       (w_reg_dst),
        .o_reg_write     (w_reg_write),
        .o_alu_src_a     (w_alu_src_a),
        .o_alu_src_b     (w_alu_src_b),
        .o_alu_op        (w_alu_op),
        .o_pc_source     (w_pc_source),
        .o_retire        (w_retire),
        .o_illegal_op    (w_illegal_op)
    );

    // Reset forces every output low; a timeout cycle drops all strobes.
    always_comb begin
        o_pc_write      = w_pc_write;
        o_pc_write_cond = w_pc_write_cond;
        o_branch_cond   = w_branch_cond;
        o_ir_write      = w_ir_write;
        o_i_or_d        = w_i_or_d;
        o_mem_read      = w_mem_read;
        o_mem_write     = w_mem_write;
        o_mem_to_reg    = w_mem_to_reg;
        o_reg_dst       = w_reg_dst;
        o_reg_write     = w_reg_write;
        o_alu_src_a     = w_alu_src_a;
        o_alu_src_b     = w_alu_src_b;
        o_alu_op        = w_alu_op;
        o_pc_source     = w_pc_source;
        o_retire        = w_retire;
        o_illegal_op    = w_illegal_op;
        o_mem_fault     = r_mem_fault;
        o_state_dbg     = r_state;

        if (i_reset) begin
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_branch_cond   = '0;
            o_ir_write      = 1'b0;
            o_i_or_d        = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_mem_to_reg    = 1'b0;
            o_reg_dst       = 1'b0;
            o_reg_write     = 1'b0;
            o_alu_src_a     = 1'b0;
            o_alu_src_b     = '0;
            o_alu_op        = '0;
            o_pc_source     = '0;
            o_retire        = 1'b0;
            o_illegal_op    = 1'b0;
            o_mem_fault     = 1'b0;
            o_state_dbg     = '0;
        end else if (w_timeout) begin
            o_pc_write      = 1'b0;
            o_pc_write_cond = 1'b0;
            o_ir_write      = 1'b0;
            o_mem_read      = 1'b0;
            o_mem_write     = 1'b0;
            o_reg_write     = 1'b0;
            o_retire        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic       mem_ready = 1'b1;

    logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retire, illegal_op, mem_fault;
    logic [1:0] branch_cond, alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic [3:0] state_dbg;
    logic [25:0] all_out;

    int n_vec = 0;
    int n_err = 0;

    assign all_out = {pc_write, pc_write_cond, branch_cond, ir_write, i_or_d, mem_read,
                      mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_op, pc_source, retire, illegal_op, mem_fault, state_dbg};

    multicycle_control #(
        .OPCODE_W    (4),
        .ALU_OP_W    (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_opcode        (opcode),
        .i_mem_ready     (mem_ready),
        .o_pc_write      (pc_write),
        .o_pc_write_cond (pc_write_cond),
        .o_branch_cond   (branch_cond),
        .o_ir_write      (ir_write),
        .o_i_or_d        (i_or_d),
        .o_mem_read      (mem_read),
        .o_mem_write     (mem_write),
        .o_mem_to_reg    (mem_to_reg),
        .o_reg_dst       (reg_dst),
        .o_reg_write     (reg_write),
        .o_alu_src_a     (alu_src_a),
        .o_alu_src_b     (alu_src_b),
        .o_alu_op        (alu_op),
        .o_pc_source     (pc_source),
        .o_retire        (retire),
        .o_illegal_op    (illegal_op),
        .o_mem_fault     (mem_fault),
        .o_state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            tick();
            #1;
            n_vec++;
            if (all_out !== 26'd0) begin
                n_err++;
                $display("FAIL reset_outputs c%0d: got %h want 0", c, all_out);
            end
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (state_dbg !== 4'd0) begin
            n_err++;
            $display("FAIL reset_release_state: got %0d want 0", state_dbg);
        end
        n_vec++;
        if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin
            n_err++;
            $display("FAIL reset_release_fetch: got %b want 11101",
                     {mem_read, ir_write, pc_write, alu_src_b});
        end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd4};
        opcode = 4'b0000;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) opcode = 4'b1111;  // must be ignored after DECODE
            #1;
            n_vec++;
            if (state_dbg !== exp_st[c]) begin
                n_err++;
                $display("FAIL rtype_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]);
            end
            n_vec++;
            if (retire !== 1'(c == 3)) begin
                n_err++;
                $display("FAIL rtype_retire c%0d: got %b want %b", c, retire, c == 3);
            end
            if (c == 2) begin
                n_vec++;
                if ({alu_src_a, alu_src_b, alu_op} !== 6'b1_00_010) begin
                    n_err++;
                    $display("FAIL rtype_exec: got %b want 100010", {alu_src_a, alu_src_b, alu_op});
                end
            end
            if (c == 3) begin
                n_vec++;
                if ({reg_dst, reg_write, mem_to_reg} !== 3'b110) begin
                    n_err++;
                    $display("FAIL rtype_wb: got %b want 110", {reg_dst, reg_write, mem_to_reg});
                end
            end
            tick();
        end
    endtask

    task automatic test_subi();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd3, 4'd4};
        opcode = 4'b0100;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (state_dbg !== exp_st[c]) begin
                n_err++;
                $display("FAIL subi_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]);
            end
            if (c == 2) begin
                n_vec++;
                if ({alu_src_a, alu_src_b, alu_op} !== 6'b1_10_001) begin
                    n_err++;
                    $display("FAIL subi_exec: got %b want 110001", {alu_src_a, alu_src_b, alu_op});
                end
            end
            if (c == 3) begin
                n_vec++;
                if ({reg_dst, reg_write, retire} !== 3'b011) begin
                    n_err++;
                    $display("FAIL subi_wb: got %b want 011", {reg_dst, reg_write, retire});
                end
            end
            tick();
        end
    endtask

    task automatic test_lhw_wait();
        logic [3:0] exp_st [8] = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd7};
        logic [7:0] rdy = 8'b1100_0111;
        logic [7:0] exp_rd = 8'b0111_1001;
        opcode = 4'b0111;
        for (int c = 0; c < 8; c++) begin
            mem_ready = rdy[c];
            #1;
            n_vec++;
            if (state_dbg !== exp_st[c]) begin
                n_err++;
                $display("FAIL lhw_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]);
            end
            n_vec++;
            if (mem_read !== exp_rd[c]) begin
                n_err++;
                $display("FAIL lhw_mem_read c%0d: got %b want %b", c, mem_read, exp_rd[c]);
            end
            n_vec++;
            if ({mem_to_reg, reg_write, retire} !== {3{1'(c == 7)}}) begin
                n_err++;
                $display("FAIL lhw_wb c%0d: got %b want %b", c,
                         {mem_to_reg, reg_write, retire}, {3{1'(c == 7)}});
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_shw();
        logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd5, 4'd8};
        opcode = 4'b1000;
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_vec++;
            if (state_dbg !== exp_st[c]) begin
                n_err++;
                $display("FAIL shw_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]);
            end
            n_vec++;
            if ({mem_write, i_or_d, retire, reg_write} !== {{3{1'(c == 3)}}, 1'b0}) begin
                n_err++;
                $display("FAIL shw_strobes c%0d: got %b want %b", c,
                         {mem_write, i_or_d, retire, reg_write}, {{3{1'(c == 3)}}, 1'b0});
            end
            tick();
        end
    endtask

    task automatic test_bgt();
        logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd9};
        opcode = 4'b1100;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if (state_dbg !== exp_st[c]) begin
                n_err++;
                $display("FAIL bgt_state c%0d: got %0d want %0d", c, state_dbg, exp_st[c]);
            end
            n_vec++;
            if (pc_write_cond !== 1'(c == 2)) begin
                n_err++;
                $display("FAIL bgt_pwc c%0d: got %b want %b", c, pc_write_cond, c == 2);
            end
            if (c == 2) begin
                n_vec++;
                if ({branch_cond, pc_source, alu_op, retire} !== 8'b11_01_001_1) begin
                    n_err++;
                    $display("FAIL bgt_branch: got %b want 11010011",
                             {branch_cond, pc_source, alu_op, retire});
                end
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        opcode = 4'b0101;
        mem_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++;
            if ({state_dbg, illegal_op, retire} !== {4'(c), 1'(c == 1), 1'b0}) begin
                n_err++;
                $display("FAIL illegal c%0d: got %b want %b", c,
                         {state_dbg, illegal_op, retire}, {4'(c), 1'(c == 1), 1'b0});
            end
            tick();
        end
        #1;
        n_vec++;
        if ({state_dbg, illegal_op, retire} !== 6'b0000_0_0) begin
            n_err++;
            $display("FAIL illegal_after: got %b want 000000", {state_dbg, illegal_op, retire});
        end
    endtask

    task automatic test_timeout_sticky();
        logic [3:0] exp_st [3] = '{4'd0, 4'd1, 4'd10};
        mem_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_vec++;
            if ({state_dbg, mem_fault, mem_read, ir_write} !== {4'd0, 1'(c == 4), 1'(c != 3), 1'b0})
            begin
                n_err++;
                $display("FAIL timeout c%0d: got %b want %b", c,
                         {state_dbg, mem_fault, mem_read, ir_write},
                         {4'd0, 1'(c == 4), 1'(c != 3), 1'b0});
            end
            tick();
        end
        // Fault stays set across a following jump.
        opcode = 4'b1111;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_vec++;
            if ({state_dbg, mem_fault} !== {exp_st[c], 1'b1}) begin
                n_err++;
                $display("FAIL jump_state c%0d: got %b want %b", c,
                         {state_dbg, mem_fault}, {exp_st[c], 1'b1});
            end
            if (c == 2) begin
                n_vec++;
                if ({pc_write, pc_source, retire} !== 4'b1_10_1) begin
                    n_err++;
                    $display("FAIL jump_ctrl: got %b want 1101", {pc_write, pc_source, retire});
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_write();
        opcode = 4'b1000;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        n_vec++;
        if ({state_dbg, mem_write, retire} !== {4'd8, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL midwr_wait: got %b want 100010", {state_dbg, mem_write, retire});
        end
        tick();
        reset = 1'b1;
        #1;
        n_vec++;
        if (all_out !== 26'd0) begin
            n_err++;
            $display("FAIL midwr_reset_cycle: got %h want 0", all_out);
        end
        tick();
        reset = 1'b0;
        #1;
        n_vec++;
        if ({state_dbg, mem_fault, mem_write, mem_read} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL midwr_after: got %b want 0000001",
                     {state_dbg, mem_fault, mem_write, mem_read});
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_subi();
        test_lhw_wait();
        test_shw();
        test_bgt();
        test_illegal();
        test_timeout_sticky();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
